encoder_16to4_serial: RTL

ENCODER_16TO4_SERIAL -- requirements
Module: encoder_16to4_serial

---
 rtl/encoder_16to4_serial.sv | 112 +++++++++++
 1 files changed

// File: rtl/encoder_16to4_serial.sv
// Captures a multi-hot 16-bit vector and streams the indices of its set bits,
// one per accepted handshake, in LSB-first or MSB-first order.
module encoder_16to4_serial #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_vec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic [4:0]  out_cnt,
    output logic        zero_err
);

    localparam int unsigned VEC_W = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [VEC_W-1:0]   pending, pending_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               zero_err_n;
    logic               valid_n;
    logic [IDX_W-1:0]   idx_n;
    logic               last_n;

    function automatic logic [CNT_W-1:0] popcount(input logic [VEC_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(VEC_W); i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Priority pick: the last assignment in scan order wins.
    function automatic logic [IDX_W-1:0] pick(input logic [VEC_W-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(VEC_W); i++) begin
            if (LSB_FIRST) begin
                if (v[VEC_W-1-i]) r = IDX_W'(VEC_W-1-i);
            end else begin
                if (v[i]) r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    // Next-state and next-output logic; outputs are precomputed from the next pending set.
    always_comb begin
        state_n    = state;
        pending_n  = pending;
        cnt_n      = out_cnt;
        zero_err_n = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_vec != '0) begin
                        pending_n = in_vec;
                        cnt_n     = popcount(in_vec);
                        state_n   = SCAN;
                    end else begin
                        zero_err_n = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_ready) begin
                    pending_n = pending & ~(VEC_W'(1) << out_idx);
                    if (out_last) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        valid_n = (state_n == SCAN);
        idx_n   = valid_n ? pick(pending_n) : '0;
        last_n  = valid_n && (popcount(pending_n) == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_cnt   <= '0;
            zero_err  <= 1'b0;
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            in_ready  <= (state_n == IDLE);
            out_valid <= valid_n;
            out_idx   <= idx_n;
            out_last  <= last_n;
            out_cnt   <= cnt_n;
            zero_err  <= zero_err_n;
        end
    end

endmodule
